// File: rtl/stack_pkg.sv
// Shared types and helpers for the stack spill/fill controller.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_REQ  = 2'd2,
    READ_WAIT = 2'd3
  } state_t;

  // Bits needed to hold a count in the range 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spill_deque.sv
// Circular spill buffer: head side faces the on-chip stack, tail side faces memory.
module spill_deque
  import stack_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BUF   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  head_push,
  input  logic [WIDTH-1:0]      head_din,
  input  logic                  head_pop,
  output logic [WIDTH-1:0]      head_dout,
  input  logic                  tail_pop,
  output logic [WIDTH-1:0]      tail_dout,
  input  logic                  tail_ins,
  input  logic [WIDTH-1:0]      tail_din,
  output logic [cnt_w(BUF)-1:0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(BUF);
  localparam int CW = cnt_w(BUF);

  logic [WIDTH-1:0] mem_q [BUF];
  logic [PW-1:0]    base_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    cnt_lo, head_idx, push_idx, ins_idx;

  // Entries live at base_q (tail) .. base_q+count-1 (head), modulo BUF.
  assign cnt_lo    = count_q[PW-1:0];
  assign head_idx  = base_q + cnt_lo - PW'(1);
  assign push_idx  = base_q + cnt_lo;
  assign ins_idx   = base_q - PW'(1);
  assign head_dout = mem_q[head_idx];
  assign tail_dout = mem_q[base_q];
  assign count     = count_q;
  assign full      = (count_q == CW'(BUF));
  assign empty     = (count_q == '0);

  always_ff @(posedge clk) begin
    if (head_push) mem_q[push_idx] <= head_din;
    if (tail_ins)  mem_q[ins_idx]  <= tail_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(head_push) + CW'(tail_ins) - CW'(head_pop) - CW'(tail_pop);
      if (tail_pop)      base_q <= base_q + PW'(1);
      else if (tail_ins) base_q <= ins_idx;
    end
  end

endmodule

// File: rtl/stack_spill_fill.sv
// Spills the bottom of the on-chip stack into a small deque and a memory-backed region,
// and refills it ahead of pops.
//   state     | meaning
//   IDLE      | no memory transaction outstanding
//   WRITE     | tail entry offered to memory at BASE+mem_count
//   READ_REQ  | read of BASE+mem_count-1 offered to memory
//   READ_WAIT | read accepted, waiting for mem_rvalid
module stack_spill_fill
  import stack_pkg::*;
#(
  parameter int                    WIDTH      = 32,
  parameter int                    DEPTH      = 2,
  parameter int                    BUF        = 4,
  parameter int                    HIGH_WATER = 3,
  parameter int                    LOW_WATER  = 1,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      bottom_in,
  output logic [WIDTH-1:0]      below_out,
  output logic                  stall,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_rvalid,
  output logic [ADDR_WIDTH:0]   total_count
);

  localparam int OCW = cnt_w(DEPTH);
  localparam int BCW = cnt_w(BUF);
  localparam int TW  = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [OCW-1:0]        onchip_q;
  logic [ADDR_WIDTH-1:0] mem_count_q;
  logic                  underflow_q;
  logic [BCW-1:0]        buf_count;
  logic                  buf_full, buf_empty;
  logic [WIDTH-1:0]      head_dout, tail_dout;
  logic                  onchip_full, rd_pending, push_only, pop_only;
  logic                  push_acc, pop_acc, spill, fill_pop, wr_done, rd_acc, rd_done;

  assign onchip_full = (onchip_q == OCW'(DEPTH));
  assign push_only   = push & ~pop;
  assign pop_only    = pop & ~push;
  assign rd_pending  = (state_q == READ_REQ) || (state_q == READ_WAIT);

  // An in-flight refill counts as a buffer slot, and pops wait for it rather than skip it.
  assign stall = (push_only & onchip_full & (buf_full | (rd_pending & (buf_count == BCW'(BUF-1)))))
               | (pop_only & onchip_full & buf_empty & ((mem_count_q != '0) | rd_pending))
               | (pop_only & onchip_full & (buf_count == BCW'(1)) & (state_q == WRITE));

  assign push_acc = push_only & ~stall;
  assign pop_acc  = pop_only & ~stall & (onchip_q != '0);
  assign spill    = push_acc & onchip_full;
  assign fill_pop = pop_acc & onchip_full & ~buf_empty;
  assign wr_done  = (state_q == WRITE) & mem_ready;
  assign rd_acc   = (state_q == READ_REQ) & mem_ready;
  assign rd_done  = (state_q == READ_WAIT) & mem_rvalid;

  spill_deque #(.WIDTH(WIDTH), .BUF(BUF)) u_deque (
    .clk       (clk),
    .reset_n   (reset_n),
    .head_push (spill),
    .head_din  (bottom_in),
    .head_pop  (fill_pop),
    .head_dout (head_dout),
    .tail_pop  (wr_done),
    .tail_dout (tail_dout),
    .tail_ins  (rd_done),
    .tail_din  (mem_rdata),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign below_out   = buf_empty ? '0 : head_dout;
  assign underflow   = underflow_q;
  assign total_count = TW'(onchip_q) + TW'(buf_count) + TW'(mem_count_q)
                     + TW'(state_q == READ_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      onchip_q    <= '0;
      mem_count_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc && !onchip_full)  onchip_q <= onchip_q + OCW'(1);
      else if (pop_acc && !fill_pop) onchip_q <= onchip_q - OCW'(1);
      if (wr_done)     mem_count_q <= mem_count_q + ADDR_WIDTH'(1);
      else if (rd_acc) mem_count_q <= mem_count_q - ADDR_WIDTH'(1);
      if (pop_only && onchip_q == '0) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (buf_count >= BCW'(HIGH_WATER))
          state_d = WRITE;
        else if (buf_count <= BCW'(LOW_WATER) && mem_count_q != '0)
          state_d = READ_REQ;
      end
      WRITE:     if (mem_ready)  state_d = IDLE;
      READ_REQ:  if (mem_ready)  state_d = READ_WAIT;
      READ_WAIT: if (mem_rvalid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = BASE + mem_count_q;
        mem_wdata = tail_dout;
      end
      READ_REQ: begin
        mem_re   = 1'b1;
        mem_addr = BASE + mem_count_q - ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_spill_fill.sv
// Self-checking bench: a full-stack reference model, a memory model and a below_out scoreboard.
module tb_stack_spill_fill;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int BUF   = 4;
  localparam int AW    = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             push = 1'b0, pop = 1'b0;
  logic             mem_ready = 1'b1, mem_rvalid = 1'b0;
  logic [WIDTH-1:0] bottom_in, below_out, mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic             stall, underflow, mem_we, mem_re;
  logic [AW-1:0]    mem_addr;
  logic [AW:0]      total_count;

  int n_cmp = 0, n_err = 0;
  logic [WIDTH-1:0] sr [DEPTH];
  logic [WIDTH-1:0] ref_stack [$];
  logic [WIDTH-1:0] sb_below [$];
  logic [WIDTH-1:0] mem_arr [16];
  logic [WIDTH-1:0] rd_buf;
  int mem_occ = 0, rd_wait = 0, wr_seen = 0, rd_seen = 0;
  logic last_we, last_re;

  always #5 clk = ~clk;
  assign bottom_in = sr[DEPTH-1];

  stack_spill_fill #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BUF(BUF), .HIGH_WATER(3), .LOW_WATER(1),
    .ADDR_WIDTH(AW), .BASE('0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .bottom_in(bottom_in), .below_out(below_out), .stall(stall), .underflow(underflow),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .total_count(total_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: a write lands in the slot that sits just above the memory-resident part
  // of the reference stack; reads return data a few cycles after acceptance.
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_rvalid = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      if (rd_wait != 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_buf;
        end
      end
      if (mem_we && mem_ready) begin
        wr_seen++;
        check("wr_addr", mem_addr, mem_occ);
        if (ref_stack.size() > mem_occ)
          check("wr_data", mem_wdata, ref_stack[ref_stack.size()-1-mem_occ]);
        else
          check("wr_depth", ref_stack.size(), mem_occ + 1);
        mem_arr[mem_occ % 16] = mem_wdata;
        mem_occ++;
      end
      if (mem_re && mem_ready) begin
        rd_seen++;
        check("rd_addr", mem_addr, mem_occ - 1);
        mem_occ--;
        rd_buf  = mem_arr[mem_occ % 16];
        rd_wait = 3;
      end
    end
  end

  // One core cycle: drive at posedge+1, sample at negedge, update the stack models afterwards.
  task automatic do_op(input logic p, input logic q, input logic [WIDTH-1:0] v, output logic st);
    logic [WIDTH-1:0] exp_b, blw;
    push = p;
    pop  = q;
    if (q && !p) sb_below.push_back((ref_stack.size() > DEPTH) ? ref_stack[DEPTH] : '0);
    @(negedge clk);
    st      = stall;
    blw     = below_out;
    last_we = mem_we;
    last_re = mem_re;
    check("total_count", total_count, ref_stack.size());
    if (q && !p) begin
      exp_b = sb_below.pop_front();
      if (!st && ref_stack.size() != 0) check("below_out", blw, exp_b);
    end
    @(posedge clk);
    #1;
    if (!st) begin
      if (p && q) begin
        if (ref_stack.size() != 0) ref_stack[0] = v;
        sr[0] = v;
      end else if (p) begin
        ref_stack.push_front(v);
        for (int i = DEPTH - 1; i > 0; i--) sr[i] = sr[i-1];
        sr[0] = v;
      end else if (q && ref_stack.size() != 0) begin
        void'(ref_stack.pop_front());
        for (int i = 0; i < DEPTH - 1; i++) sr[i] = sr[i+1];
        sr[DEPTH-1] = blw;
      end
    end
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic idle(input int n);
    logic st;
    repeat (n) do_op(1'b0, 1'b0, '0, st);
  endtask

  task automatic pop_retry(output int stalls);
    logic st;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      do_op(1'b0, 1'b1, '0, st);
      if (!st) return;
      stalls++;
    end
    check("pop_retry_timeout", stalls, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    ref_stack.delete();
    sb_below.delete();
    for (int i = 0; i < DEPTH; i++) sr[i] = '0;
    mem_occ = 0;
    rd_wait = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    int   stalls;
    for (int i = 0; i < DEPTH; i++) sr[i] = '0;

    // Reset values while reset is held.
    #3;
    check("rst_total", total_count, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_underflow", underflow, 0);
    check("rst_below", below_out, 0);
    do_reset();

    // Fill on-chip only: no memory traffic.
    for (int v = 1; v <= 2; v++) begin
      do_op(1'b1, 1'b0, WIDTH'(v), st);
      check("push_onchip_stall", st, 0);
    end
    idle(4);
    check("onchip_no_write", wr_seen, 0);

    // Spill until the buffer crosses the high-water mark: one write of 1 at BASE+0.
    for (int v = 3; v <= 5; v++) begin
      do_op(1'b1, 1'b0, WIDTH'(v), st);
      check("push_spill_stall", st, 0);
    end
    idle(4);
    check("spill_write_count", wr_seen, 1);

    // Pops: 3 then 2 from the buffer, then a refill of 1 that the next pop waits for.
    do_op(1'b0, 1'b1, '0, st);
    check("pop1_stall", st, 0);
    do_op(1'b0, 1'b1, '0, st);
    check("pop2_stall", st, 0);
    pop_retry(stalls);
    check("refill_stalled", (stalls > 0), 1);
    check("refill_read_count", rd_seen, 1);
    do_op(1'b0, 1'b1, '0, st);
    check("pop4_stall", st, 0);
    do_op(1'b0, 1'b1, '0, st);

    // Memory not ready with buffer and on-chip full: the push stalls until the write lands.
    mem_ready = 1'b0;
    for (int v = 11; v <= 16; v++) begin
      do_op(1'b1, 1'b0, WIDTH'(v), st);
      check("fill_push_stall", st, 0);
    end
    for (int k = 0; k < 3; k++) begin
      do_op(1'b1, 1'b0, WIDTH'(17), st);
      check("full_push_stall", st, 1);
      check("held_we", mem_we, 1);
      check("held_addr", mem_addr, 0);
    end
    mem_ready = 1'b1;
    do_op(1'b1, 1'b0, WIDTH'(17), st);
    check("release_cycle_stall", st, 1);
    do_op(1'b1, 1'b0, WIDTH'(17), st);
    check("after_release_stall", st, 0);
    idle(6);

    // Simultaneous push and pop at full: top replaced, nothing else moves.
    do_op(1'b1, 1'b1, WIDTH'(99), st);
    check("pp_stall", st, 0);
    check("pp_we", last_we, 0);
    check("pp_re", last_re, 0);
    check("pp_total", total_count, 7);

    // Drain everything, refilling from memory along the way.
    for (int k = 0; k < 7; k++) pop_retry(stalls);
    idle(2);
    check("drained_total", total_count, 0);

    // Pop on an empty stack: not stalled, underflow sticks.
    do_op(1'b0, 1'b1, '0, st);
    check("uf_stall", st, 0);
    check("uf_set", underflow, 1);
    do_op(1'b1, 1'b0, WIDTH'(42), st);
    check("uf_sticky", underflow, 1);

    // Reset in the middle of a write that memory never accepts.
    mem_ready = 1'b0;
    for (int v = 43; v <= 46; v++) do_op(1'b1, 1'b0, WIDTH'(v), st);
    idle(2);
    check("mid_write_we", mem_we, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_total", total_count, 0);
    check("rst_mid_underflow", underflow, 0);
    mem_ready = 1'b1;
    do_reset();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
